// File: rtl/sram_sched_if.sv
// rtl/sram_sched_if.sv - request/response and SRAM pin bundle for sram_sched
interface sram_sched_if #(
   parameter int AW = 21
);
   logic          cfgE;
   logic          cfgD;
   logic          init;
   logic          iniReq;
   logic          iniAck;
   logic [AW-1:0] iniA;
   logic [7:0]    iniD;
   logic          cpuRd;
   logic          cpuWr;
   logic [AW-1:0] cpuA;
   logic [7:0]    cpuD;
   logic [7:0]    cpuQ;
   logic          cpuAck;
   logic          sramWe;
   logic [AW-1:0] sramA;
   logic [7:0]    dqO;
   logic          dqOe;
   logic [7:0]    dqI;

   modport master (
      output init, iniReq, iniA, iniD, cpuRd, cpuWr, cpuA, cpuD, dqI,
      input  cfgE, cfgD, iniAck, cpuQ, cpuAck, sramWe, sramA, dqO, dqOe
   );

   modport slave (
      input  init, iniReq, iniA, iniD, cpuRd, cpuWr, cpuA, cpuD, dqI,
      output cfgE, cfgD, iniAck, cpuQ, cpuAck, sramWe, sramA, dqO, dqOe
   );
endinterface

// File: rtl/sram_sched.sv
// rtl/sram_sched.sv - boot/loader/core scheduler for one async 8-bit SRAM (optional read cache: SRAM_RDCACHE_EN)
module sram_sched #(
   parameter int            AW      = 21,
   parameter logic [AW-1:0] CFGADDR = AW'(21'h08FD5),
   parameter int            CFGDLY  = 3,
   parameter int            WRCYC   = 2,
   parameter int            RDCYC   = 2
) (
   input logic         clock,
   input logic         reset,
   sram_sched_if.slave bus
);

   localparam logic [7:0] CFG_LAST  = 8'(CFGDLY - 1);
   localparam logic [7:0] WR_LAST   = 8'(WRCYC - 1);
   // dqI is captured one cycle before the end of RD so cpuQ is already valid when cpuAck shows;
   // this needs RDCYC >= 2
   localparam logic [7:0] RD_SAMPLE = 8'(RDCYC - 2);
   localparam logic [7:0] RD_LAST   = 8'(RDCYC - 1);

   typedef enum logic [2:0] {S_CFG, S_IDLE, S_WSET, S_WLOW, S_WREL, S_RD} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic          we;
   logic          oe;
   logic [AW-1:0] addr;
   logic [7:0]    dout;
   logic          cfg_e;
   logic          cfg_d;
   logic [7:0]    q;
   logic          ini_ack;
   logic          cpu_ack;
   logic          wr_cpu;

   logic          go_wr;
   logic          go_rd;
   logic [AW-1:0] req_a;
   logic [7:0]    req_d;

`ifdef SRAM_RDCACHE_EN
   logic          c_valid;
   logic [AW-1:0] c_tag;
   logic [7:0]    c_data;
   logic          init_q;
   logic          hit;

   assign hit = go_rd && c_valid && (c_tag == bus.cpuA);
`endif

   // Owner selection in IDLE; nothing is accepted while an ack pulse is still out
   always_comb begin
      go_wr = 1'b0;
      go_rd = 1'b0;
      req_a = bus.cpuA;
      req_d = bus.cpuD;
      if (state == S_IDLE && !ini_ack && !cpu_ack) begin
         if (!bus.init) begin
            go_wr = bus.iniReq;
            req_a = bus.iniA;
            req_d = bus.iniD;
         end else begin
            go_wr = bus.cpuWr;
            go_rd = bus.cpuRd && !bus.cpuWr;
         end
      end
   end

   // Sequencer: config read, write strobe timing, read timing; all pin outputs registered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_CFG;
         cnt     <= 8'd0;
         we      <= 1'b1;
         oe      <= 1'b0;
         addr    <= CFGADDR;
         dout    <= 8'd0;
         cfg_e   <= 1'b0;
         cfg_d   <= 1'b0;
         q       <= 8'd0;
         ini_ack <= 1'b0;
         cpu_ack <= 1'b0;
         wr_cpu  <= 1'b0;
`ifdef SRAM_RDCACHE_EN
         c_valid <= 1'b0;
         c_tag   <= '0;
         c_data  <= 8'd0;
         init_q  <= 1'b0;
`endif
      end else begin
         ini_ack <= 1'b0;
         cpu_ack <= 1'b0;
         case (state)
            S_CFG: begin
               addr <= CFGADDR;
               we   <= 1'b1;
               oe   <= 1'b0;
               if (cnt == CFG_LAST) begin
                  cfg_d <= bus.dqI[0];
                  cfg_e <= 1'b1;
                  cnt   <= 8'd0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_IDLE: begin
               if (go_wr) begin
                  addr   <= req_a;
                  dout   <= req_d;
                  oe     <= 1'b1;
                  wr_cpu <= bus.init;
                  state  <= S_WSET;
               end else if (go_rd) begin
`ifdef SRAM_RDCACHE_EN
                  if (hit) begin
                     q       <= c_data;
                     cpu_ack <= 1'b1;
                  end else begin
                     addr  <= req_a;
                     cnt   <= 8'd0;
                     state <= S_RD;
                  end
`else
                  addr  <= req_a;
                  cnt   <= 8'd0;
                  state <= S_RD;
`endif
               end
            end
            S_WSET: begin
               we    <= 1'b0;
               cnt   <= 8'd0;
               state <= S_WLOW;
            end
            S_WLOW: begin
               if (cnt == WR_LAST) begin
                  we      <= 1'b1;
                  ini_ack <= !wr_cpu;
                  cpu_ack <= wr_cpu;
                  state   <= S_WREL;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WREL: begin
               oe    <= 1'b0;
               state <= S_IDLE;
            end
            S_RD: begin
               if (cnt == RD_SAMPLE) begin
                  q       <= bus.dqI;
                  cpu_ack <= 1'b1;
               end
               if (cnt == RD_LAST) begin
                  cnt   <= 8'd0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_CFG;
         endcase
`ifdef SRAM_RDCACHE_EN
         init_q <= bus.init;
         if (go_wr && c_valid && (c_tag == req_a))
            c_data <= req_d;
         if (state == S_RD && cnt == RD_SAMPLE) begin
            c_valid <= 1'b1;
            c_tag   <= addr;
            c_data  <= bus.dqI;
         end
         // the loader may rewrite anything once init drops, so the entry cannot be trusted
         if (init_q && !bus.init)
            c_valid <= 1'b0;
`endif
      end
   end

   assign bus.sramWe = we;
   assign bus.sramA  = addr;
   assign bus.dqO    = dout;
   assign bus.dqOe   = oe;
   assign bus.cfgE   = cfg_e;
   assign bus.cfgD   = cfg_d;
   assign bus.cpuQ   = q;
   assign bus.iniAck = ini_ack;
   assign bus.cpuAck = cpu_ack;

endmodule
